pipe_elastic_reg: RTL and testbench

// - Parametrised successor to the fixed IF/ID, ID/EXE, EXE/MEM and MEM/WB latches: a STAGES-deep elastic

---
 rtl/pipe_pkg.sv | 9 +
 rtl/pipe_skid_stage.sv | 75 +++++++
 rtl/pipe_elastic_reg.sv | 49 ++++
 tb/tb_pipe_elastic_reg.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared NOP encoding and per-stage occupancy states for the elastic pipeline register.
package pipe_pkg;
  localparam logic [31:0] BUBBLE_NOP = 32'h0000_0000;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_e;
endpackage

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: one main+skid register stage with valid/ready handshake and synchronous flush.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(BUBBLE_NOP)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       count_o
);
  stage_e st_q, st_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic acc;
  assign acc = in_valid_i & in_ready_o;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= ST_EMPTY;
      main_q <= BUBBLE;
      skid_q <= BUBBLE;
    end else begin
      st_q   <= st_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
  // Empty slots always reload BUBBLE so out_data shows the NOP whenever out_valid is low.
  always_comb begin
    st_d   = st_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush_i) begin
      st_d   = ST_EMPTY;
      main_d = BUBBLE;
      skid_d = BUBBLE;
    end else begin
      case (st_q)
        ST_EMPTY: if (acc) begin
          st_d   = ST_ONE;
          main_d = in_data_i;
        end
        ST_ONE: if (acc && !out_ready_i) begin
          st_d   = ST_TWO;
          skid_d = in_data_i;
        end else if (acc) begin
          main_d = in_data_i;
        end else if (out_ready_i) begin
          st_d   = ST_EMPTY;
          main_d = BUBBLE;
        end
        ST_TWO: if (out_ready_i) begin
          st_d   = ST_ONE;
          main_d = skid_q;
          skid_d = BUBBLE;
        end
        default: begin
          st_d   = ST_EMPTY;
          main_d = BUBBLE;
          skid_d = BUBBLE;
        end
      endcase
    end
  end
  assign in_ready_o  = st_q != ST_TWO;
  assign out_valid_o = st_q != ST_EMPTY;
  assign out_data_o  = main_q;
  assign count_o     = st_q == ST_TWO ? 2'd2 : st_q == ST_ONE ? 2'd1 : 2'd0;
endmodule

// File: rtl/pipe_elastic_reg.sv
// pipe_elastic_reg: STAGES-deep elastic pipeline register between CPU stages.
// Ready is registered in every stage, so there is no combinational ready path end to end.
module pipe_elastic_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               STAGES = 1,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(BUBBLE_NOP)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [WIDTH-1:0]                 in_data_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [WIDTH-1:0]                 out_data_o,
  input  logic                             flush_i,
  output logic [$clog2(2*STAGES+1)-1:0]    occupancy_o
);
  localparam int OW = $clog2(2*STAGES+1);
  logic [STAGES:0] vld, rdy;
  logic [WIDTH-1:0] dat [STAGES+1];
  logic [1:0] cnt [STAGES];
  assign vld[0]      = in_valid_i;
  assign dat[0]      = in_data_i;
  assign in_ready_o  = rdy[0];
  assign rdy[STAGES] = out_ready_i;
  assign out_valid_o = vld[STAGES];
  assign out_data_o  = dat[STAGES];
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    pipe_skid_stage #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_stage (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (flush_i),
      .in_valid_i (vld[s]),
      .in_ready_o (rdy[s]),
      .in_data_i  (dat[s]),
      .out_valid_o(vld[s+1]),
      .out_ready_i(rdy[s+1]),
      .out_data_o (dat[s+1]),
      .count_o    (cnt[s])
    );
  end
  always_comb begin
    occupancy_o = '0;
    for (int k = 0; k < STAGES; k++) occupancy_o = occupancy_o + OW'(cnt[k]);
  end
endmodule

// File: tb/tb_pipe_elastic_reg.sv
// tb_pipe_elastic_reg: three instances (STAGES=1,2,3) checked against a queue-based scoreboard.
module tb_pipe_elastic_reg;
  localparam logic [31:0] BUB = 32'h0;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  logic [2:0] in_valid, out_ready, flush, in_ready, out_valid;
  logic [2:0][31:0] in_data, out_data;
  logic [2:0][3:0] occ;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int OW = $clog2(2*(g+1)+1);
    logic [OW-1:0] o;
    pipe_elastic_reg #(.WIDTH(32), .STAGES(g+1), .BUBBLE(BUB)) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .in_valid_i (in_valid[g]),
      .in_ready_o (in_ready[g]),
      .in_data_i  (in_data[g]),
      .out_valid_o(out_valid[g]),
      .out_ready_i(out_ready[g]),
      .out_data_o (out_data[g]),
      .flush_i    (flush[g]),
      .occupancy_o(o)
    );
    assign occ[g] = 4'(o);
  end
  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] mq [3][64];
  int mt [3][64];
  int hd [3], tl [3], dlv [3];
  logic [2:0] xi, xo, st;
  logic [2:0][31:0] pod;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      hd[k] = 0;
      tl[k] = 0;
    end
  endtask
  task automatic idle();
    in_valid  = '0;
    flush     = '0;
    out_ready = '1;
    in_data   = '0;
  endtask
  // Scoreboard: FIFO of accepted beats; output must always present the oldest one.
  task automatic tick();
    for (int k = 0; k < 3; k++) begin
      xi[k]  = in_valid[k] & in_ready[k];
      xo[k]  = out_valid[k] & out_ready[k];
      st[k]  = out_valid[k] & ~out_ready[k] & ~flush[k];
      pod[k] = out_data[k];
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      int n;
      if (xo[k]) begin
        chk($sformatf("underflow%0d", k), 32'(tl[k] - hd[k] > 0), 1);
        chk($sformatf("order%0d", k), pod[k], mq[k][hd[k] % 64]);
        hd[k]++;
        dlv[k]++;
      end
      if (flush[k]) hd[k] = tl[k];
      else if (xi[k]) begin
        mq[k][tl[k] % 64] = in_data[k];
        mt[k][tl[k] % 64] = cyc - 1;
        tl[k]++;
      end
      n = tl[k] - hd[k];
      chk($sformatf("occ%0d", k), 32'(occ[k]), 32'(n));
      if (!out_valid[k]) chk($sformatf("bubble%0d", k), out_data[k], BUB);
      else begin
        chk($sformatf("valid_empty%0d", k), 32'(n > 0), 1);
        if (n > 0) begin
          chk($sformatf("head%0d", k), out_data[k], mq[k][hd[k] % 64]);
          chk($sformatf("early%0d", k), 32'(cyc >= mt[k][hd[k] % 64] + k + 1), 1);
        end
      end
      if (n == 0) chk($sformatf("rdy_empty%0d", k), 32'(in_ready[k]), 1);
      if (n == 2*(k+1)) chk($sformatf("rdy_full%0d", k), 32'(in_ready[k]), 0);
      if (st[k]) begin
        chk($sformatf("hold_v%0d", k), 32'(out_valid[k]), 1);
        chk($sformatf("hold_d%0d", k), out_data[k], pod[k]);
      end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    int got, sent, d0;
    idle();
    model_clear();
    for (int k = 0; k < 3; k++) dlv[k] = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_v%0d", k), 32'(out_valid[k]), 0);
      chk($sformatf("rst_r%0d", k), 32'(in_ready[k]), 1);
      chk($sformatf("rst_o%0d", k), 32'(occ[k]), 0);
      chk($sformatf("rst_d%0d", k), out_data[k], BUB);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    // 1: STAGES=2 latency and back-to-back stream
    in_valid[1] = 1; in_data[1] = 32'h11; tick();
    chk("t1_lat", 32'(out_valid[1]), 0);
    in_data[1] = 32'h22; tick();
    chk("t1_v", 32'(out_valid[1]), 1);
    chk("t1_11", out_data[1], 32'h11);
    in_data[1] = 32'h33; tick();
    chk("t1_22", out_data[1], 32'h22);
    in_valid[1] = 0; tick();
    chk("t1_33", out_data[1], 32'h33);
    tick();
    chk("t1_end", 32'(out_valid[1]), 0);
    // 2: STAGES=1 stall absorbs two beats
    out_ready[0] = 0; in_valid[0] = 1; in_data[0] = 32'hA0; tick();
    in_data[0] = 32'hA1; tick();
    in_data[0] = 32'hA2;
    chk("t2_full", 32'(in_ready[0]), 0);
    chk("t2_occ", 32'(occ[0]), 2);
    chk("t2_a0", out_data[0], 32'hA0);
    tick();
    chk("t2_still", 32'(in_ready[0]), 0);
    out_ready[0] = 1; tick();
    chk("t2_a1", out_data[0], 32'hA1);
    chk("t2_rdy", 32'(in_ready[0]), 1);
    tick();
    chk("t2_a2", out_data[0], 32'hA2);
    in_valid[0] = 0; tick();
    chk("t2_end", 32'(out_valid[0]), 0);
    // 3: STAGES=3 flush with five beats in flight
    out_ready[2] = 0; in_valid[2] = 1; got = 0;
    for (int i = 0; i < 20 && got < 5; i++) begin
      in_data[2] = 32'hC0 + 32'(got);
      if (in_ready[2]) got++;
      tick();
    end
    chk("t3_fill", 32'(got), 5);
    chk("t3_occ", 32'(occ[2]), 5);
    in_data[2] = 32'hFF; flush[2] = 1; tick();
    chk("t3_occ0", 32'(occ[2]), 0);
    chk("t3_v0", 32'(out_valid[2]), 0);
    chk("t3_bub", out_data[2], BUB);
    chk("t3_rdy", 32'(in_ready[2]), 1);
    flush[2] = 0; in_valid[2] = 0; out_ready[2] = 1;
    repeat (6) begin
      tick();
      chk("t3_noff", 32'(out_valid[2]), 0);
    end
    // 4: STAGES=2 toggling out_ready with 16 continuous beats
    sent = 0; d0 = dlv[1];
    for (int i = 0; i < 200 && dlv[1] - d0 < 16; i++) begin
      out_ready[1] = (i % 2 == 0);
      in_valid[1]  = sent < 16;
      in_data[1]   = 32'(sent);
      if (in_valid[1] && in_ready[1]) sent++;
      tick();
    end
    chk("t4_count", 32'(dlv[1] - d0), 16);
    idle();
    // 5: asynchronous reset between edges with four beats held
    out_ready[1] = 0; in_valid[1] = 1; got = 0;
    for (int i = 0; i < 20 && got < 4; i++) begin
      in_data[1] = 32'hB0 + 32'(got);
      if (in_ready[1]) got++;
      tick();
    end
    in_valid[1] = 0;
    chk("t5_fill", 32'(occ[1]), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_v", 32'(out_valid[1]), 0);
    chk("t5_o", 32'(occ[1]), 0);
    chk("t5_r", 32'(in_ready[1]), 1);
    model_clear();
    idle();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    // 6: flush coinciding with an output transfer
    in_valid[2] = 1; in_data[2] = 32'h55; tick();
    in_data[2] = 32'h56; tick();
    in_data[2] = 32'h57; tick();
    in_valid[2] = 0;
    chk("t6_55", out_data[2], 32'h55);
    d0 = dlv[2];
    flush[2] = 1; tick();
    flush[2] = 0;
    chk("t6_dlv", 32'(dlv[2] - d0), 1);
    chk("t6_occ", 32'(occ[2]), 0);
    repeat (5) begin
      tick();
      chk("t6_kill", 32'(out_valid[2]), 0);
    end
    // random traffic on all three depths
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 3; k++) begin
        in_valid[k]  = $urandom_range(0, 3) != 0;
        in_data[k]   = $urandom;
        out_ready[k] = $urandom_range(0, 2) != 0;
        flush[k]     = $urandom_range(0, 19) == 0;
      end
      tick();
    end
    idle();
    repeat (10) tick();
    for (int k = 0; k < 3; k++) chk($sformatf("drain%0d", k), 32'(tl[k] - hd[k]), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
